// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared definitions for the SPI slave receiver.
//   - default FIFO depth and synchronizer length
//   - dout bit positions and the empty-FIFO read word
//   - Hack memory-map address of the read register
//   - receiver state encoding and FIFO entry layout
package spi_rx_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_SYNC  = 2;

    // dout layout: {overflow, 5'b0, first, cd, byte[7:0]}
    localparam int OVF_BIT   = 15;
    localparam int FIRST_BIT = 9;
    localparam int CD_BIT    = 8;
    localparam int BYTE_MSB  = 7;
    localparam int BYTE_LSB  = 0;

    localparam logic [15:0] EMPTY_WORD = 16'hFFFF;

    // Read register, placed next to the existing spi_* write addresses.
    localparam logic [14:0] SPI_RX_ADDR = 15'h6003;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic       first;
        logic       cd;
        logic [7:0] data;
    } rx_entry_t;

    function automatic logic [15:0] pack_word(input logic ovf, input rx_entry_t e);
        logic [15:0] w;
        w                    = '0;
        w[OVF_BIT]           = ovf;
        w[FIRST_BIT]         = e.first;
        w[CD_BIT]            = e.cd;
        w[BYTE_MSB:BYTE_LSB] = e.data;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers.
//   clk, rstn      : clock, synchronous active-low reset
//   push, din      : write request and data
//   pop            : remove head; ignored when empty
//   head           : current head entry (valid when !empty)
//   full, empty    : status
// A push while full is accepted only if a pop happens in the same cycle,
// in which case the freed slot is reused.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_rx.sv
// spi_rx: SPI mode-0 slave receiver with tagged byte FIFO.
//   clk, rstn            : system clock, synchronous active-low reset
//   spi_sck/mosi/cdn/cen : SPI lines from the master, asynchronous to clk
//   rd                   : 1-cycle pulse, pop FIFO head
//   clr                  : 1-cycle pulse, clear the overflow flag
//   dout                 : {overflow, 5'b0, first, cd, byte}, 16'hFFFF when empty
//   empty                : FIFO empty
//   rcv                  : 1-cycle pulse per completed byte
//   overflow             : sticky, a byte was dropped on a full FIFO
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | cen high (or not yet seen high since reset); bitcnt = 0
// ST_SHIFT | inside a cen-low frame, sampling mosi on each sck rise
module spi_rx
    import spi_rx_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SYNC  = DEFAULT_SYNC
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_cdn,
    input  logic        spi_cen,
    input  logic        rd,
    input  logic        clr,
    output logic [15:0] dout,
    output logic        empty,
    output logic        rcv,
    output logic        overflow
);

    logic [SYNC-1:0] sck_sync;
    logic [SYNC-1:0] mosi_sync;
    logic [SYNC-1:0] cdn_sync;
    logic [SYNC-1:0] cen_sync;
    logic [SYNC-1:0] cen_fill;
    logic            sck_prev;

    logic            sck_s;
    logic            mosi_s;
    logic            cdn_s;
    logic            cen_s;
    logic            sck_rise;

    rx_state_e       state;
    logic [2:0]      bitcnt;
    logic [6:0]      sh;
    logic            first_pending;
    logic            armed;

    logic            sample_last;
    rx_entry_t       push_entry;
    rx_entry_t       head;
    logic            fifo_full;
    logic            fifo_empty;

    // Synchronizers. cen idles high so it resets to 1; the others reset to 0.
    // cen_fill tracks when the cen chain holds real pin samples rather than
    // reset values, so a low cen at reset release is not mistaken for a fall.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cdn_sync  <= '0;
            cen_sync  <= '1;
            cen_fill  <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC-2:0], spi_mosi};
            cdn_sync  <= {cdn_sync[SYNC-2:0], spi_cdn};
            cen_sync  <= {cen_sync[SYNC-2:0], spi_cen};
            cen_fill  <= {cen_fill[SYNC-2:0], 1'b1};
            sck_prev  <= sck_s;
        end
    end

    assign sck_s    = sck_sync[SYNC-1];
    assign mosi_s   = mosi_sync[SYNC-1];
    assign cdn_s    = cdn_sync[SYNC-1];
    assign cen_s    = cen_sync[SYNC-1];
    assign sck_rise = sck_s && !sck_prev;

    assign sample_last = (state == ST_SHIFT) && !cen_s && sck_rise && (bitcnt == 3'd7);
    assign push_entry  = {first_pending, cdn_s, sh, mosi_s};

    // A frame may only start after cen has been genuinely seen high since
    // reset; this is what makes a reset abort the rest of the current frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            bitcnt        <= '0;
            sh            <= '0;
            first_pending <= 1'b1;
            armed         <= 1'b0;
            rcv           <= 1'b0;
        end else begin
            rcv <= sample_last;
            if (cen_fill[SYNC-1] && cen_s) armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    bitcnt        <= '0;
                    first_pending <= 1'b1;
                    if (armed && !cen_s) state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cen_s) begin
                        // Any partial byte is simply dropped.
                        state         <= ST_IDLE;
                        bitcnt        <= '0;
                        first_pending <= 1'b1;
                    end else if (sck_rise) begin
                        sh     <= {sh[5:0], mosi_s};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) first_pending <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Drop wins only when no pop frees a slot; set beats a same-cycle clr.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (sample_last && fifo_full && !rd) begin
            overflow <= 1'b1;
        end else if (clr) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (sample_last),
        .pop   (rd),
        .din   (push_entry),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign empty = fifo_empty;
    assign dout  = fifo_empty ? EMPTY_WORD : pack_word(overflow, head);

endmodule

// File: tb/tb_spi_rx.sv
module tb_spi_rx;

    localparam int DEPTH   = 4;
    localparam int SYNC    = 2;
    localparam int PH      = 5;
    localparam int FAST_NS = (SYNC + 1) * 10;

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        spi_sck  = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cdn  = 1'b0;
    logic        spi_cen  = 1'b1;
    logic        rd       = 1'b0;
    logic        clr      = 1'b0;
    logic [15:0] dout;
    logic        empty;
    logic        rcv;
    logic        overflow;

    int errors  = 0;
    int checks  = 0;
    int rcv_cnt = 0;

    // Reference model: ordered list of {first, cd, byte} plus sticky flag.
    logic [9:0] mq[$];
    logic       m_ovf = 1'b0;

    spi_rx #(.DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_cdn  (spi_cdn),
        .spi_cen  (spi_cen),
        .rd       (rd),
        .clr      (clr),
        .dout     (dout),
        .empty    (empty),
        .rcv      (rcv),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rcv === 1'b1) rcv_cnt++;

    function automatic logic [15:0] m_word();
        if (mq.size() == 0) return 16'hFFFF;
        return {m_ovf, 5'b00000, mq[0]};
    endfunction

    task automatic m_push(input logic first, input logic cd, input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back({first, cd, b});
        else m_ovf = 1'b1;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-0 bit; optional rd/clr pulse lands on the sampling clock edge.
    task automatic spi_bit(input logic b, input logic rd_l, input logic clr_l);
        spi_mosi = b;
        wait_clk(PH);
        spi_sck = 1'b1;
        if (rd_l || clr_l) begin
            wait_clk(SYNC);
            rd  = rd_l;
            clr = clr_l;
            wait_clk(1);
            rd  = 1'b0;
            clr = 1'b0;
            wait_clk(PH - SYNC - 1);
        end else begin
            wait_clk(PH);
        end
        spi_sck = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, input logic cd,
                            input logic rd_l, input logic clr_l);
        spi_cdn = cd;
        for (int i = 7; i > 7 - n; i--) spi_bit(b[i], rd_l && (i == 0), clr_l && (i == 0));
    endtask

    task automatic frame_start();
        spi_cen = 1'b0;
        wait_clk(PH + 2);
    endtask

    task automatic frame_end();
        wait_clk(PH);
        spi_cen = 1'b1;
        wait_clk(SYNC + 4);
    endtask

    task automatic pop_head();
        rd = 1'b1;
        wait_clk(1);
        rd = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        spi_cen = 1'b1;
        wait_clk(3);
        checks++; if (dout !== 16'hFFFF) begin errors++; $display("FAIL reset_dout: got %h want ffff", dout); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (rcv !== 1'b0) begin errors++; $display("FAIL reset_rcv: got %b want 0", rcv); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rstn = 1'b1;
        wait_clk(SYNC + 3);
        checks++; if (dout !== 16'hFFFF) begin errors++; $display("FAIL idle_dout: got %h want ffff", dout); end
    endtask

    task automatic test_command();
        int c0 = rcv_cnt;
        frame_start();
        spi_bits(8'hAF, 8, 1'b0, 1'b0, 1'b0);
        frame_end();
        m_push(1'b1, 1'b0, 8'hAF);
        checks++; if (rcv_cnt - c0 != 1) begin errors++; $display("FAIL cmd_rcv_count: got %0d want 1", rcv_cnt - c0); end
        checks++; if (dout !== m_word()) begin errors++; $display("FAIL cmd_dout: got %h want %h", dout, m_word()); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL cmd_empty: got %b want 0", empty); end
        pop_head();
        checks++; if (dout !== m_word()) begin errors++; $display("FAIL cmd_after_rd: got %h want %h", dout, m_word()); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL cmd_empty_after_rd: got %b want 1", empty); end
    endtask

    task automatic test_d16();
        logic [7:0] hi, lo;
        for (int r = 0; r < 3; r++) begin
            hi = (r == 0) ? 8'h12 : 8'($urandom);
            lo = (r == 0) ? 8'h34 : 8'($urandom);
            frame_start();
            spi_bits(hi, 8, 1'b1, 1'b0, 1'b0);
            spi_bits(lo, 8, 1'b1, 1'b0, 1'b0);
            frame_end();
            m_push(1'b1, 1'b1, hi);
            m_push(1'b0, 1'b1, lo);
            for (int k = 0; k < 2; k++) begin
                checks++; if (dout !== m_word()) begin errors++; $display("FAIL d16_word%0d: got %h want %h", k, dout, m_word()); end
                pop_head();
            end
            checks++; if (empty !== 1'b1) begin errors++; $display("FAIL d16_empty: got %b want 1", empty); end
        end
    endtask

    task automatic test_abort();
        int c0 = rcv_cnt;
        frame_start();
        spi_bits(8'($urandom), 5, 1'b1, 1'b0, 1'b0);
        frame_end();
        frame_start();
        spi_bits(8'h55, 8, 1'b1, 1'b0, 1'b0);
        frame_end();
        m_push(1'b1, 1'b1, 8'h55);
        checks++; if (rcv_cnt - c0 != 1) begin errors++; $display("FAIL abort_rcv_count: got %0d want 1", rcv_cnt - c0); end
        checks++; if (dout !== m_word()) begin errors++; $display("FAIL abort_dout: got %h want %h", dout, m_word()); end
        pop_head();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL abort_single_entry: empty got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        frame_start();
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            spi_bits(b, 8, 1'b1, 1'b0, 1'b0);
            m_push(i == 0, 1'b1, b);
        end
        frame_end();
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_set: got %b want %b", overflow, m_ovf); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (dout !== m_word()) begin errors++; $display("FAIL ovf_readback%0d: got %h want %h", i, dout, m_word()); end
            pop_head();
        end
        checks++; if (dout !== 16'hFFFF || empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got dout=%h empty=%b want ffff 1", dout, empty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        clr = 1'b1;
        wait_clk(1);
        clr   = 1'b0;
        m_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", overflow); end

        // Full FIFO: push with a coincident rd, then push with a coincident clr.
        frame_start();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            spi_bits(b, 8, 1'b1, 1'b0, 1'b0);
            m_push(i == 0, 1'b1, b);
        end
        b = 8'($urandom);
        spi_bits(b, 8, 1'b1, 1'b1, 1'b0);
        void'(mq.pop_front());
        m_push(1'b0, 1'b1, b);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_push_with_rd: got %b want 0", overflow); end
        b = 8'($urandom);
        spi_bits(b, 8, 1'b1, 1'b0, 1'b1);
        m_push(1'b0, 1'b1, b);
        frame_end();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clr: got %b want 1", overflow); end
        while (mq.size() > 0) begin
            checks++; if (dout !== m_word()) begin errors++; $display("FAIL ovf_full_readback: got %h want %h", dout, m_word()); end
            pop_head();
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] b;
        int c0;
        b = 8'($urandom);
        frame_start();
        spi_bits(b, 8, 1'b0, 1'b0, 1'b0);
        frame_end();
        m_push(1'b1, 1'b0, b);
        checks++; if (dout !== m_word()) begin errors++; $display("FAIL rst_pre_dout: got %h want %h", dout, m_word()); end

        c0 = rcv_cnt;
        b  = 8'($urandom);
        frame_start();
        spi_bits(b, 4, 1'b1, 1'b0, 1'b0);
        rstn = 1'b0;
        wait_clk(2);
        mq.delete();
        m_ovf = 1'b0;
        checks++; if (dout !== 16'hFFFF) begin errors++; $display("FAIL rst_mid_dout: got %h want ffff", dout); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b want 1", empty); end
        checks++; if (rcv !== 1'b0) begin errors++; $display("FAIL rst_mid_rcv: got %b want 0", rcv); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow: got %b want 0", overflow); end
        rstn = 1'b1;
        spi_bits(b << 4, 4, 1'b1, 1'b0, 1'b0);
        wait_clk(PH);
        checks++; if (empty !== 1'b1 || rcv_cnt != c0) begin errors++; $display("FAIL rst_no_push: got empty=%b rcvs=%0d want 1 0", empty, rcv_cnt - c0); end
        frame_end();

        b = 8'($urandom);
        frame_start();
        spi_bits(b, 8, 1'b1, 1'b0, 1'b0);
        frame_end();
        m_push(1'b1, 1'b1, b);
        checks++; if (dout !== m_word()) begin errors++; $display("FAIL rst_next_frame: got %h want %h", dout, m_word()); end
        checks++; if (rcv_cnt - c0 != 1) begin errors++; $display("FAIL rst_next_rcv: got %0d want 1", rcv_cnt - c0); end
        pop_head();
    endtask

    task automatic test_timing();
        int total = 0;
        int n, c0, dly;
        logic [7:0] b;
        logic cd;
        while (total < 256) begin
            n = int'($urandom_range(1, DEPTH));
            if (n > 256 - total) n = 256 - total;
            c0  = rcv_cnt;
            dly = int'($urandom_range(1, 9));
            @(posedge clk);
            #(dly);
            spi_cen = 1'b0;
            #(FAST_NS + 10);
            for (int k = 0; k < n; k++) begin
                b  = 8'($urandom);
                cd = 1'($urandom);
                spi_cdn = cd;
                for (int i = 7; i >= 0; i--) begin
                    spi_mosi = b[i];
                    #(FAST_NS);
                    spi_sck = 1'b1;
                    #(FAST_NS);
                    spi_sck = 1'b0;
                end
                m_push(k == 0, cd, b);
            end
            #(FAST_NS);
            spi_cen = 1'b1;
            #(60);
            wait_clk(1);
            checks++; if (rcv_cnt - c0 != n) begin errors++; $display("FAIL timing_rcv_count: got %0d want %0d", rcv_cnt - c0, n); end
            while (mq.size() > 0) begin
                checks++; if (dout !== m_word()) begin errors++; $display("FAIL timing_byte%0d: got %h want %h", total, dout, m_word()); end
                pop_head();
            end
            checks++; if (empty !== 1'b1) begin errors++; $display("FAIL timing_empty: got %b want 1", empty); end
            total += n;
        end
    endtask

    initial begin
        test_reset();
        test_command();
        test_d16();
        test_abort();
        test_overflow();
        test_reset_mid_byte();
        test_timing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_rx.md
# spi_rx

SPI slave receiver for the screen link: the receiving end of the Hack SPI master's mosi/sck/cdn/cen interface. It oversamples the four SPI lines on clk and deserialises MSB-first bytes. Each byte is tagged with its command/data flag and a first-in-frame flag, then buffered in a small FIFO. The Hack CPU reads the FIFO through a memory-mapped 16-bit register, and the same block serves as the display-side model in benches.

## Interface
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- SYNC, 2: synchronizer flops per SPI input; ≥2.
- clk  in  1  system clock (100 MHz).
- rstn  in  1  reset, synchronous, active-low.
- spi_sck  in  1  SPI clock from master, async to clk.
- spi_mosi  in  1  serial data, MSB first.
- spi_cdn  in  1  0 = command byte, 1 = data byte.
- spi_cen  in  1  chip enable, active-low; frames a transfer.
- rd  in  1  1-cycle pulse: pop FIFO head.
- clr  in  1  1-cycle pulse: clear overflow flag.
- dout  out  16  head word: {overflow, 5'b0, first, cd, byte[7:0]}; 16'hFFFF when empty.
- empty  out  1  FIFO empty.
- rcv  out  1  1-cycle pulse when a byte is pushed.
- overflow  out  1  sticky; a byte was dropped on a full FIFO.

## Operation
- Input conditioning: each SPI pin passes through a SYNC-stage flop chain. sck_rise is defined as synchronized sck going 0→1 (previous-sample compare).
- SPI mode 0: sample mosi on sck_rise only while synchronized cen = 0. Falling sck edges are ignored.
- Shift register: sh <= {sh[6:0], mosi}. A 3-bit counter bitcnt counts 0..7.
- On the sample with bitcnt = 7:
  - byte = {sh[6:0], mosi}; cd = cdn sampled on that same cycle.
  - first = 1 if this is the first complete byte since cen fell.
  - Push {first, cd, byte}, pulse rcv, bitcnt → 0.
- State machine:
  - IDLE: cen = 1, bitcnt = 0, first_pending = 1.
  - SHIFT: entered on synchronized cen falling. Stays while cen = 0. Returns to IDLE on cen rising.
  - A partial byte (bitcnt ≠ 0) at cen rise is discarded silently.
- 16-bit transfers (D16) arrive as two bytes in one frame: first = 1 then first = 0, both cd = 1. Software reassembles them.
- FIFO rules:
  - push & !full: write entry.
  - push & full & !rd: drop byte, set overflow.
  - push & full & rd: pop head and push new byte; no overflow.
  - rd & empty: ignored.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and the low bits are equal.
- overflow: set has priority over a simultaneous clr.
- dout is combinational from head entry, overflow and empty.

## Timing
- Reset (rstn = 0 at clk edge) values:
  - dout = 16'hFFFF, empty = 1, rcv = 0, overflow = 0.
  - bitcnt = 0, state IDLE, FIFO pointers = 0, sync flops = 1 for cen and 0 for the others.
- Reset during a transfer aborts it. Reception restarts only at the next cen falling edge.
- Latency:
  - pin sck rise → sample: SYNC+1 clk.
  - 8th sample → rcv and entry visible on dout: +1 clk. empty falls on that same cycle.
- rd at cycle n: the next head (or FFFF) appears on dout at n+1.
- Master constraint: sck high and low phases ≥ SYNC+1 clk each. The master's BAUD=5 setting (5 clk per phase) satisfies this for SYNC = 2 or 3.
- cen setup: cen must fall ≥ SYNC+1 clk before the first sck rise.
- cdn must be stable from the 8th sck rise until SYNC+1 clk after it.

## Structure
- Shared header spi_rx.vh holds:
  - default DEPTH and SYNC.
  - dout bit positions: OVF = 15, FIRST = 9, CD = 8, BYTE = 7:0.
  - EMPTY_WORD = 16'hFFFF.
- Hack memory-map address for the read register is defined alongside the existing spi_* addresses.
- One sub-module, sync_fifo, parameterised by WIDTH (10) and DEPTH. It provides push/pop/full/empty/head and owns the pointer logic. spi_rx contains the synchronizers, edge detect, shifter, FSM and overflow flag.

## Test plan
- Command byte: cen low, cdn = 0, shift 0xAF, cen high → one rcv pulse; dout = 16'h02AF (first = 1, cd = 0); rd → dout = 16'hFFFF, empty = 1.
- D16 frame: cdn = 1, shift 0x12 then 0x34 in one cen frame → dout = 16'h0312, then after rd 16'h0134.
- Abort: 5 bits then cen high, then a full byte 0x55 with cdn = 1 → exactly one entry, dout = 16'h0355; no residue from the partial byte.
- Overflow: 5 bytes without rd (DEPTH = 4) → 5th dropped, dout[15] = 1, first four bytes read back in order. clr → overflow = 0. Push and rd together while full → no overflow.
- Reset mid-byte: rstn low after 4 bits → all outputs at reset values. A byte then completing within the same cen frame is not pushed; the next frame receives normally.
- Timing margin: sck phases of SYNC+1 clk with random sck/clk phase offset → 256 random bytes received in order with matching cd flags.
